// File: rtl/piso_shift_param.sv
// piso_shift_param: parallel-in/serial-out shift register with a load
// handshake, a shift-enable stall input and a per-word selectable bit order.
// A new word can be taken on the same edge that consumes the final bit of
// the current word, so back-to-back words stream with no idle gap.
module piso_shift_param #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] in,
  input  logic             lsb_first,
  input  logic             shift_en,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ord_q, ord_d;

  logic at_last;
  logic do_load;

  // Handshake and final-bit detection; ready depends only on state and shift_en.
  always_comb begin
    at_last    = (state_q == ST_SHIFT) && (cnt_q == CNT_MAX);
    load_ready = (state_q == ST_IDLE) || (at_last && shift_en);
    do_load    = load_valid && load_ready;
  end

  // Next-state logic: a load wins, otherwise an enabled shift advances or finishes the word.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ord_d   = ord_q;
    if (do_load) begin
      state_d = ST_SHIFT;
      sr_d    = in;
      cnt_d   = '0;
      ord_d   = lsb_first ^ !MSB_FIRST;
    end else if ((state_q == ST_SHIFT) && shift_en) begin
      if (at_last) begin
        state_d = ST_IDLE;
      end else begin
        sr_d  = ord_q ? (sr_q >> 1) : (sr_q << 1);
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State registers; reset aborts any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ord_q   <= !MSB_FIRST;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ord_q   <= ord_d;
    end
  end

  // Serial outputs come straight from registered state.
  always_comb begin
    busy      = (state_q == ST_SHIFT);
    out_valid = busy;
    last      = at_last;
    out       = busy ? (ord_q ? sr_q[0] : sr_q[WIDTH-1]) : IDLE_LEVEL;
  end

endmodule

// File: tb/tb_piso_shift_param.sv
// Testbench for piso_shift_param: an 8-bit instance checked every cycle
// against a queue-of-bits reference model, plus a 2-bit instance with an
// idle level of 1 checked against hand-computed sequences.
module tb_piso_shift_param;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       load_valid8 = 1'b0;
  logic       load_ready8;
  logic [7:0] in8 = '0;
  logic       lsb_first8 = 1'b0;
  logic       shift_en8 = 1'b0;
  logic       out8, out_valid8, last8, busy8;

  logic       load_valid2 = 1'b0;
  logic       load_ready2;
  logic [1:0] in2 = '0;
  logic       lsb_first2 = 1'b0;
  logic       shift_en2 = 1'b0;
  logic       out2, out_valid2, last2, busy2;

  int vectors = 0;
  int miscompares = 0;

  piso_shift_param #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut8 (
    .clk(clk), .rst(rst),
    .load_valid(load_valid8), .load_ready(load_ready8),
    .in(in8), .lsb_first(lsb_first8), .shift_en(shift_en8),
    .out(out8), .out_valid(out_valid8), .last(last8), .busy(busy8)
  );

  piso_shift_param #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut2 (
    .clk(clk), .rst(rst),
    .load_valid(load_valid2), .load_ready(load_ready2),
    .in(in2), .lsb_first(lsb_first2), .shift_en(shift_en2),
    .out(out2), .out_valid(out_valid2), .last(last2), .busy(busy2)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Reference model: the bits still to be sent for the current word, in send order.
  bit model_q[$];

  // Model update: a word is ready to load when nothing is pending, or when
  // the final pending bit is being consumed this edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
    end else begin
      bit ready_m;
      bit lsb_m;
      ready_m = (model_q.size() == 0) || (model_q.size() == 1 && shift_en8);
      if (load_valid8 && ready_m) begin
        model_q.delete();
        lsb_m = lsb_first8;
        for (int k = 0; k < 8; k++)
          model_q.push_back(lsb_m ? in8[k] : in8[7-k]);
      end else if (model_q.size() > 0 && shift_en8) begin
        void'(model_q.pop_front());
      end
    end
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
    end
  endtask

  // Every falling edge, compare all 8-bit instance outputs with the model.
  always @(negedge clk) begin
    logic exp_out, exp_busy, exp_last, exp_ready;
    exp_busy  = (model_q.size() > 0);
    exp_out   = exp_busy ? model_q[0] : 1'b0;
    exp_last  = (model_q.size() == 1);
    exp_ready = (model_q.size() == 0) || (model_q.size() == 1 && shift_en8);
    checkOutput("model_out", out8, exp_out);
    checkOutput("model_out_valid", out_valid8, exp_busy);
    checkOutput("model_busy", busy8, exp_busy);
    checkOutput("model_last", last8, exp_last);
    checkOutput("model_load_ready", load_ready8, exp_ready);
  end

  // Drive the 8-bit instance inputs for one cycle and step past the next edge.
  task automatic applyStimulus(input logic lv, input logic [7:0] data,
                               input logic lsb, input logic sen);
    load_valid8 = lv;
    in8         = data;
    lsb_first8  = lsb;
    shift_en8   = sen;
    @(posedge clk);
    #1;
  endtask

  // Load one word with shift_en high and check the serial stream against a
  // hand-computed sequence (seq[7] is the first bit on the wire).
  task automatic directedWord(input string name, input logic [7:0] data,
                              input logic lsb, input logic [7:0] seq);
    applyStimulus(1'b1, data, lsb, 1'b1);
    for (int k = 0; k < 8; k++) begin
      checkOutput({name, "_bit"}, out8, seq[7-k]);
      checkOutput({name, "_last"}, last8, (k == 7));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    end
    checkOutput({name, "_idle_out"}, out8, 1'b0);
    checkOutput({name, "_idle_valid"}, out_valid8, 1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    logic [10:0] sen_pat;
    logic [15:0] stream;
    logic [3:0]  seq2;
    int consumed;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", load_ready8, 1'b1);
    checkOutput("reset_busy", busy8, 1'b0);
    checkOutput("reset_out2_idle", out2, 1'b1);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] directed words");
    directedWord("msb_a5", 8'hA5, 1'b0, 8'hA5);
    directedWord("lsb_a5", 8'hA5, 1'b1, 8'hA5);
    directedWord("lsb_01", 8'h01, 1'b1, 8'h80);

    $display("[TB] stall pattern");
    applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0);
    sen_pat  = 11'b11111011001;
    consumed = 0;
    for (int i = 0; i < 11; i++) begin
      checkOutput("stall_bit", out8, (consumed < 4));
      checkOutput("stall_last", last8, (consumed == 7));
      if (!sen_pat[i]) begin
        shift_en8 = 1'b0;
        #1;
        checkOutput("stall_ready", load_ready8, 1'b0);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, sen_pat[i]);
      if (sen_pat[i]) consumed++;
    end
    checkOutput("stall_done", busy8, 1'b0);

    $display("[TB] back-to-back words");
    stream = 16'b1000000101111110;
    applyStimulus(1'b1, 8'h81, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("b2b_bit", out8, stream[15-i]);
      checkOutput("b2b_valid", out_valid8, 1'b1);
      checkOutput("b2b_last", last8, (i == 7 || i == 15));
      applyStimulus((i < 8), 8'h7E, 1'b0, 1'b1);
    end
    checkOutput("b2b_done", out_valid8, 1'b0);

    $display("[TB] reset mid-word");
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("rst_out", out8, 1'b0);
    checkOutput("rst_busy", busy8, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("rst_no_bits", out_valid8, 1'b0);
    end
    directedWord("after_rst_c3", 8'hC3, 1'b0, 8'hC3);

    $display("[TB] WIDTH=2 instance");
    seq2 = 4'b1010;
    load_valid2 = 1'b1; in2 = 2'b10; shift_en2 = 1'b1; lsb_first2 = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("w2_bit", out2, seq2[3-i]);
      checkOutput("w2_last", last2, (i == 1 || i == 3));
      checkOutput("w2_valid", out_valid2, 1'b1);
      load_valid2 = (i == 1);
      @(posedge clk); #1;
    end
    checkOutput("w2_idle_out", out2, 1'b1);
    checkOutput("w2_idle_valid", out_valid2, 1'b0);
    load_valid2 = 1'b0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        rst = 1'b1;
        #1;
        checkOutput("rand_rst_busy", busy8, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
      end else begin
        applyStimulus(($urandom_range(0, 1) == 1), 8'($urandom),
                      ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7));
      end
    end

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
